// File: rtl/tx_frame_mux_4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tx_frame_mux_4                                               |
// | Description : Frame-locked 4:1 byte-stream mux that follows a round-robin  |
// |               arbiter. It holds the granted source for a whole frame,      |
// |               forwards it through a registered output stage, caps the      |
// |               frame at MAX_FRAME_LEN beats and drains any over-length tail.|
// | Ports       : clock/reset       - rising-edge clock, sync active-high reset|
// |               in_data/valid/last- four source byte streams (source i at    |
// |                                   in_data[i*DATA_WIDTH +: DATA_WIDTH])      |
// |               in_ready          - per-source accept                        |
// |               request/grant     - arbiter handshake (request only in IDLE) |
// |               out_*             - registered output beat with frame info   |
// |               out_ready         - downstream accept                        |
// |               grant_error       - sticky, multi-hot grant seen in IDLE     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tx_frame_mux_4 #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1518
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*DATA_WIDTH-1:0] in_data,
  input  logic [3:0]              in_valid,
  input  logic [3:0]              in_last,
  output logic [3:0]              in_ready,
  output logic [3:0]              request,
  input  logic [3:0]              grant,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic                    out_trunc,
  output logic [1:0]              out_src,
  output logic [15:0]             out_len,
  input  logic                    out_ready,
  output logic                    grant_error
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_FORWARD = 2'd1;
  localparam logic [1:0]  S_DRAIN   = 2'd2;
  localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME_LEN);

  logic [1:0]            state_q, state_d;
  logic [1:0]            sel_q;
  logic [15:0]           cnt_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  out_trunc_q;
  logic [1:0]            out_src_q;
  logic [15:0]           out_len_q;
  logic                  grant_error_q;

  logic [1:0]            grant_idx;
  logic                  grant_multi;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  out_free;
  logic                  accept;
  logic                  fwd_accept;
  logic [15:0]           cnt_inc;
  logic                  at_limit;

  // Lowest set grant bit wins if the arbiter ever misbehaves with a multi-hot grant.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (grant[i]) grant_idx = 2'(i);
    end
  end

  assign grant_multi = |(grant & (grant - 4'd1));
  assign sel_last    = in_last[sel_q];
  assign sel_data    = in_data[int'(sel_q) * DATA_WIDTH +: DATA_WIDTH];
  assign out_free    = ~out_valid_q | out_ready;
  assign accept      = |(in_valid & in_ready);
  assign fwd_accept  = accept & (state_q == S_FORWARD);
  assign cnt_inc     = cnt_q + 16'd1;
  assign at_limit    = (cnt_inc == MAX_LEN);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) state_d = S_FORWARD;
      end
      S_FORWARD: begin
        if (accept) begin
          // A limit beat that also carries last ends the frame naturally.
          if (sel_last)      state_d = S_IDLE;
          else if (at_limit) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept && sel_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: arbiter request and per-source ready
  always_comb begin
    request  = 4'd0;
    in_ready = 4'd0;
    case (state_q)
      S_IDLE:    request         = in_valid;
      S_FORWARD: in_ready[sel_q] = out_free;
      S_DRAIN:   in_ready[sel_q] = 1'b1;
      default: ;
    endcase
  end

  // Source selection, beat counter and registered output stage
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q         <= 2'd0;
      cnt_q         <= 16'd0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_trunc_q   <= 1'b0;
      out_src_q     <= 2'd0;
      out_len_q     <= 16'd0;
      grant_error_q <= 1'b0;
    end else begin
      if ((state_q == S_IDLE) && (|grant)) begin
        sel_q <= grant_idx;
        cnt_q <= 16'd0;
        if (grant_multi) grant_error_q <= 1'b1;
      end

      // Drained beats never reach this register; only FORWARD loads it.
      if (fwd_accept) begin
        cnt_q       <= cnt_inc;
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
        out_src_q   <= sel_q;
        out_last_q  <= sel_last | at_limit;
        out_trunc_q <= at_limit & ~sel_last;
        out_len_q   <= (sel_last | at_limit) ? cnt_inc : 16'd0;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_trunc   = out_trunc_q;
  assign out_src     = out_src_q;
  assign out_len     = out_len_q;
  assign grant_error = grant_error_q;

endmodule
`default_nettype wire
